// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Brief    : Fetch-stage program counter with RUN/HALT control and a circular
//            return-address stack for call/return.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_sequencer #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic [1:0]        pc_inc_i,
   input  logic [ADDR_W-1:0] abs_addr_i,
   input  logic [ADDR_W-1:0] branch_off_i,
   input  logic              push_ra_i,
   input  logic              pop_ra_i,
   input  logic              resume_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic              halted_o,
   output logic              ras_empty_o,
   output logic              ras_full_o,
   output logic [1:0]        ras_err_o
);

   localparam int               PTR_W    = $clog2(RAS_DEPTH);
   localparam int               CNT_W    = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

   localparam logic [1:0] INC_SEQ    = 2'b00;
   localparam logic [1:0] INC_BRANCH = 2'b01;
   localparam logic [1:0] INC_JUMP   = 2'b10;
   localparam logic [1:0] INC_HALT   = 2'b11;

   typedef enum logic [0:0] {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
   logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        err_q, err_d;

   logic [ADDR_W-1:0] pc_plus1;
   logic [PTR_W-1:0]  ptr_inc;
   logic              ras_empty;
   logic              ras_full;

   assign pc_plus1  = pc_q + ADDR_W'(1);
   assign ptr_inc   = ptr_q + PTR_W'(1);
   assign ras_empty = (cnt_q == '0);
   assign ras_full  = (cnt_q == FULL_CNT);

   // ptr_q always names the top slot; the slot after it is the oldest entry
   // once the stack is full, so a push there overwrites it circularly.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ras_d   = ras_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      err_d   = err_q;

      if (!stall_i) begin
         case (state_q)
            S_RUN: begin
               if (pc_inc_i == INC_HALT) begin
                  state_d = S_HALT;
               end else begin
                  if (pop_ra_i && !ras_empty) begin
                     pc_d = ras_q[ptr_q];
                  end else if (pop_ra_i) begin
                     pc_d     = pc_plus1;
                     err_d[0] = 1'b1;
                  end else begin
                     case (pc_inc_i)
                        INC_JUMP:   pc_d = abs_addr_i;
                        INC_BRANCH: pc_d = pc_plus1 + branch_off_i;
                        INC_SEQ:    pc_d = pc_plus1;
                        default:    pc_d = pc_plus1;
                     endcase
                  end

                  if (pop_ra_i && push_ra_i && !ras_empty) begin
                     ras_d[ptr_q] = pc_plus1;
                  end else if (pop_ra_i && !ras_empty) begin
                     ptr_d = ptr_q - PTR_W'(1);
                     cnt_d = cnt_q - CNT_W'(1);
                  end else if (push_ra_i) begin
                     ptr_d          = ptr_inc;
                     ras_d[ptr_inc] = pc_plus1;
                     if (ras_full) begin
                        err_d[1] = 1'b1;
                     end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                     end
                  end
               end
            end
            S_HALT: begin
               if (resume_i) begin
                  state_d = S_RUN;
               end
            end
            default: begin
               state_d = S_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RUN;
         pc_q    <= RESET_PC;
         ptr_q   <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) begin
            ras_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         ras_q   <= ras_d;
      end
   end

   assign pc_o        = pc_q;
   assign halted_o    = (state_q == S_HALT);
   assign ras_empty_o = ras_empty;
   assign ras_full_o  = ras_full;
   assign ras_err_o   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Directed scoreboard bench for pc_sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

   logic        clk;
   logic        rst;
   logic        stall_i;
   logic [1:0]  pc_inc_i;
   logic [31:0] abs_addr_i;
   logic [31:0] branch_off_i;
   logic        push_ra_i;
   logic        pop_ra_i;
   logic        resume_i;
   logic [31:0] pc_o;
   logic        halted_o;
   logic        ras_empty_o;
   logic        ras_full_o;
   logic [1:0]  ras_err_o;

   pc_sequencer #(
      .ADDR_W    (32),
      .RESET_PC  (32'h0),
      .RAS_DEPTH (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stall_i      (stall_i),
      .pc_inc_i     (pc_inc_i),
      .abs_addr_i   (abs_addr_i),
      .branch_off_i (branch_off_i),
      .push_ra_i    (push_ra_i),
      .pop_ra_i     (pop_ra_i),
      .resume_i     (resume_i),
      .pc_o         (pc_o),
      .halted_o     (halted_o),
      .ras_empty_o  (ras_empty_o),
      .ras_full_o   (ras_full_o),
      .ras_err_o    (ras_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected word: {pc, halted, ras_empty, ras_full, ras_err}
   logic [36:0] exp_q [$];
   string       name_q [$];
   int          checks = 0;
   int          fails  = 0;

   task automatic step(input string nm, input logic r, input logic st, input logic [1:0] inc,
                       input logic [31:0] abs_a, input logic [31:0] off, input logic psh,
                       input logic pp, input logic res, input logic [31:0] e_pc, input logic e_h,
                       input logic e_em, input logic e_fu, input logic [1:0] e_er);
      @(negedge clk);
      rst          = r;
      stall_i      = st;
      pc_inc_i     = inc;
      abs_addr_i   = abs_a;
      branch_off_i = off;
      push_ra_i    = psh;
      pop_ra_i     = pp;
      resume_i     = res;
      exp_q.push_back({e_pc, e_h, e_em, e_fu, e_er});
      name_q.push_back(nm);
   endtask

   // Monitor: every post-edge output is matched against the oldest expectation.
   initial begin
      logic [36:0] act;
      logic [36:0] exp_v;
      string       nm;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act   = {pc_o, halted_o, ras_empty_o, ras_full_o, ras_err_o};
            checks++;
            if (act !== exp_v) begin
               fails++;
               $display("FAIL %s: got pc=%h h=%b e=%b f=%b err=%b, want pc=%h h=%b e=%b f=%b err=%b",
                        nm, act[36:5], act[4], act[3], act[2], act[1:0],
                        exp_v[36:5], exp_v[4], exp_v[3], exp_v[2], exp_v[1:0]);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; stall_i = 1'b0; pc_inc_i = 2'b00; abs_addr_i = '0; branch_off_i = '0;
      push_ra_i = 1'b0; pop_ra_i = 1'b0; resume_i = 1'b0;

      // Reset and sequential fetch
      step("reset",     1, 0, 2'b00, 0, 0, 0, 0, 0, 32'd0, 0, 1, 0, 2'b00);
      step("seq1",      0, 0, 2'b00, 0, 0, 0, 0, 0, 32'd1, 0, 1, 0, 2'b00);
      step("seq2",      0, 0, 2'b00, 0, 0, 0, 0, 0, 32'd2, 0, 1, 0, 2'b00);
      step("seq3",      0, 0, 2'b00, 0, 0, 0, 0, 0, 32'd3, 0, 1, 0, 2'b00);
      step("seq4",      0, 0, 2'b00, 0, 0, 0, 0, 0, 32'd4, 0, 1, 0, 2'b00);

      // Branch backwards and address wrap
      step("jump10",    0, 0, 2'b10, 32'd10, 0, 0, 0, 0, 32'd10, 0, 1, 0, 2'b00);
      step("branch-3",  0, 0, 2'b01, 0, 32'hFFFF_FFFD, 0, 0, 0, 32'd8, 0, 1, 0, 2'b00);
      step("jumpmax",   0, 0, 2'b10, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 1, 0, 2'b00);
      step("wrap",      0, 0, 2'b00, 0, 0, 0, 0, 0, 32'd0, 0, 1, 0, 2'b00);

      // Call via jump then return
      step("jump5",     0, 0, 2'b10, 32'd5, 0, 0, 0, 0, 32'd5, 0, 1, 0, 2'b00);
      step("call40",    0, 0, 2'b10, 32'd40, 0, 1, 0, 0, 32'd40, 0, 0, 0, 2'b00);
      step("body41",    0, 0, 2'b00, 0, 0, 0, 0, 0, 32'd41, 0, 0, 0, 2'b00);
      step("ret6",      0, 0, 2'b00, 0, 0, 0, 1, 0, 32'd6, 0, 1, 0, 2'b00);

      // Stack overflow, drain, underflow
      step("rst2",      1, 0, 2'b00, 0, 0, 0, 0, 0, 32'd0, 0, 1, 0, 2'b00);
      step("to1",       0, 0, 2'b00, 0, 0, 0, 0, 0, 32'd1, 0, 1, 0, 2'b00);
      step("call@1",    0, 0, 2'b00, 0, 0, 1, 0, 0, 32'd2, 0, 0, 0, 2'b00);
      step("call@2",    0, 0, 2'b00, 0, 0, 1, 0, 0, 32'd3, 0, 0, 0, 2'b00);
      step("call@3",    0, 0, 2'b00, 0, 0, 1, 0, 0, 32'd4, 0, 0, 0, 2'b00);
      step("call@4",    0, 0, 2'b00, 0, 0, 1, 0, 0, 32'd5, 0, 0, 1, 2'b00);
      step("call@5ovf", 0, 0, 2'b00, 0, 0, 1, 0, 0, 32'd6, 0, 0, 1, 2'b10);
      step("pop6",      0, 0, 2'b00, 0, 0, 0, 1, 0, 32'd6, 0, 0, 0, 2'b10);
      step("pop5",      0, 0, 2'b00, 0, 0, 0, 1, 0, 32'd5, 0, 0, 0, 2'b10);
      step("pop4",      0, 0, 2'b00, 0, 0, 0, 1, 0, 32'd4, 0, 0, 0, 2'b10);
      step("pop3",      0, 0, 2'b00, 0, 0, 0, 1, 0, 32'd3, 0, 1, 0, 2'b10);
      step("popempty",  0, 0, 2'b00, 0, 0, 0, 1, 0, 32'd4, 0, 1, 0, 2'b11);
      step("call@4b",   0, 0, 2'b00, 0, 0, 1, 0, 0, 32'd5, 0, 0, 0, 2'b11);
      step("pushpop",   0, 0, 2'b00, 0, 0, 1, 1, 0, 32'd5, 0, 0, 0, 2'b11);
      step("popnew",    0, 0, 2'b00, 0, 0, 0, 1, 0, 32'd6, 0, 1, 0, 2'b11);

      // Halt, ignored inputs while halted, stalled resume, resume
      step("rst3",      1, 0, 2'b00, 0, 0, 0, 0, 0, 32'd0, 0, 1, 0, 2'b00);
      step("jump7",     0, 0, 2'b10, 32'd7, 0, 0, 0, 0, 32'd7, 0, 1, 0, 2'b00);
      step("halt",      0, 0, 2'b11, 0, 0, 1, 0, 0, 32'd7, 1, 1, 0, 2'b00);
      step("hold1",     0, 0, 2'b00, 0, 0, 0, 0, 0, 32'd7, 1, 1, 0, 2'b00);
      step("hold2",     0, 0, 2'b10, 32'd99, 0, 1, 0, 0, 32'd7, 1, 1, 0, 2'b00);
      step("hold3",     0, 0, 2'b00, 0, 0, 0, 1, 0, 32'd7, 1, 1, 0, 2'b00);
      step("stallres",  0, 1, 2'b00, 0, 0, 0, 0, 1, 32'd7, 1, 1, 0, 2'b00);
      step("resume",    0, 0, 2'b00, 0, 0, 0, 0, 1, 32'd7, 0, 1, 0, 2'b00);
      step("run8",      0, 0, 2'b00, 0, 0, 0, 0, 0, 32'd8, 0, 1, 0, 2'b00);

      // Stall freezes pc and stack; reset while halted with entries
      step("call@8",    0, 0, 2'b00, 0, 0, 1, 0, 0, 32'd9, 0, 0, 0, 2'b00);
      step("call@9",    0, 0, 2'b00, 0, 0, 1, 0, 0, 32'd10, 0, 0, 0, 2'b00);
      step("stall1",    0, 1, 2'b10, 32'd99, 0, 1, 0, 0, 32'd10, 0, 0, 0, 2'b00);
      step("stall2",    0, 1, 2'b10, 32'd99, 0, 1, 0, 0, 32'd10, 0, 0, 0, 2'b00);
      step("popafter",  0, 0, 2'b00, 0, 0, 0, 1, 0, 32'd10, 0, 0, 0, 2'b00);
      step("call@10",   0, 0, 2'b00, 0, 0, 1, 0, 0, 32'd11, 0, 0, 0, 2'b00);
      step("halt2",     0, 0, 2'b11, 0, 0, 0, 0, 0, 32'd11, 1, 0, 0, 2'b00);
      step("rsthalt",   1, 0, 2'b00, 0, 0, 0, 0, 0, 32'd0, 0, 1, 0, 2'b00);
      step("runafter",  0, 0, 2'b00, 0, 0, 0, 0, 0, 32'd1, 0, 1, 0, 2'b00);

      @(negedge clk);
      push_ra_i = 1'b0; pop_ra_i = 1'b0; pc_inc_i = 2'b00; resume_i = 1'b0; stall_i = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

`default_nettype wire
